pc_ras_unit: RTL

Parametrised successor to the accumulator machine's program-counter subsystem. It holds the PC and resolves increment, jump, BEQ/BNE, CALL and RET in one unit. It adds a hardware return-address stack (RAS) of configurable depth, with overflow/underflow detection and a selectable overflow policy. It sits between the control unit (op, pc_write), the ALU (target, zero) and the memory subsystem (pc).

---
 rtl/pc_ras_pkg.sv | 15 +
 rtl/ras_stack.sv | 76 +++++++
 rtl/pc_ras_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_ras_pkg.sv
// Shared definitions for the program-counter / return-address-stack unit.
// Operation encoding presented by the control unit on the op bus.
package pc_ras_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0] OP_INC  = 3'd1;
  localparam logic [OP_W-1:0] OP_JUMP = 3'd2;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'd3;
  localparam logic [OP_W-1:0] OP_BNE  = 3'd4;
  localparam logic [OP_W-1:0] OP_CALL = 3'd5;
  localparam logic [OP_W-1:0] OP_RET  = 3'd6;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO built as a circular buffer so a full stack can
// optionally overwrite its oldest entry instead of dropping the push.
module ras_stack
  import pc_ras_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         wrap_mode,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         push_drop,
  output logic                         pop_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;

  // sp_q always points at the next slot to write; the top sits just below it.
  assign top_idx   = (sp_q == '0) ? LAST_IDX : sp_q - 1'b1;
  assign top       = mem_q[top_idx];
  assign count     = cnt_q;
  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  // Flags a push against a full stack, whether it was dropped or overwrote.
  assign push_drop = push & full;
  assign pop_empty = pop & empty;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    if (push && (!full || wrap_mode)) begin
      wr_en = 1'b1;
      sp_d  = (sp_q == LAST_IDX) ? '0 : sp_q + 1'b1;
      if (!full) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop && !empty) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // When full in wrap mode, sp_q already addresses the oldest entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[sp_q] <= din;
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection for INC/JUMP/BEQ/BNE/CALL/RET,
// a hardware return-address stack and sticky overflow/underflow flags.
module pc_ras_unit
  import pc_ras_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter int               INC_STEP = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter bit               RAS_WRAP = 1'b0
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         pc_write,
  input  logic [OP_W-1:0]              op,
  input  logic [WIDTH-1:0]             target,
  input  logic                         zero,
  input  logic                         err_clear,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_inc,
  output logic [$clog2(DEPTH+1)-1:0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic             push, pop, push_drop, pop_empty;
  logic [WIDTH-1:0] ras_top;

  assign pc_inc        = pc_q + WIDTH'(INC_STEP);
  assign pc            = pc_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (reset),
    .push      (push),
    .pop       (pop),
    .wrap_mode (RAS_WRAP),
    .din       (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .push_drop (push_drop),
    .pop_empty (pop_empty)
  );

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (pc_write) begin
      case (op)
        OP_INC:  pc_d = pc_inc;
        OP_JUMP: pc_d = target;
        OP_BEQ:  pc_d = zero ? target : pc_inc;
        OP_BNE:  pc_d = zero ? pc_inc : target;
        OP_CALL: begin
          pc_d = target;
          push = 1'b1;
        end
        OP_RET: begin
          pop = 1'b1;
          if (!ras_empty) begin
            pc_d = ras_top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // A new error on the same edge as err_clear keeps the flag set.
  always_comb begin
    err_ovf_d = push_drop | (err_ovf_q & ~err_clear);
    err_unf_d = pop_empty | (err_unf_q & ~err_clear);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

endmodule
